// File: rtl/m6809_reset_seq.sv
// Staged reset sequencer: holds all domains in reset, releases them one at a time,
// then supervises RUN with a watchdog that re-runs the sequence on expiry.
module m6809_reset_seq #(
    parameter int unsigned NUM_DOMAINS    = 2,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 250,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   sw_reset_req,
    input  logic                   timeout_en,
    input  logic                   wdog_kick,
    output logic [NUM_DOMAINS-1:0] dom_reset_b,
    output logic                   seq_done,
    output logic                   timeout,
    output logic [7:0]             restart_cnt
);

    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_HOLD,
        S_STAGGER,
        S_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] wdog_cnt;
    logic [IDX_W-1:0] dom_idx;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state       <= S_RESET;
            phase_cnt   <= '0;
            wdog_cnt    <= '0;
            dom_idx     <= '0;
            dom_reset_b <= '0;
            seq_done    <= 1'b0;
            timeout     <= 1'b0;
            restart_cnt <= '0;
        end else if (state == S_RESET) begin
            state       <= S_HOLD;
            phase_cnt   <= '0;
            wdog_cnt    <= '0;
            dom_idx     <= '0;
            dom_reset_b <= '0;
            seq_done    <= 1'b0;
        end else if (sw_reset_req) begin
            // Software restart leaves the sticky watchdog history untouched.
            state       <= S_HOLD;
            phase_cnt   <= '0;
            wdog_cnt    <= '0;
            dom_idx     <= '0;
            dom_reset_b <= '0;
            seq_done    <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        phase_cnt   <= '0;
                        dom_reset_b <= dom_reset_b | NUM_DOMAINS'(1);
                        if (NUM_DOMAINS == 1) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            state   <= S_STAGGER;
                            dom_idx <= IDX_W'(1);
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                S_STAGGER: begin
                    if (phase_cnt == STAGGER_LAST) begin
                        phase_cnt   <= '0;
                        dom_reset_b <= dom_reset_b | (NUM_DOMAINS'(1) << dom_idx);
                        if (dom_idx == LAST_IDX) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            dom_idx <= dom_idx + IDX_W'(1);
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (wdog_kick || !timeout_en) begin
                        wdog_cnt <= '0;
                    end else if (wdog_cnt == TIMEOUT_LAST) begin
                        timeout     <= 1'b1;
                        restart_cnt <= (restart_cnt == 8'hFF) ? restart_cnt : restart_cnt + 8'd1;
                        state       <= S_HOLD;
                        phase_cnt   <= '0;
                        wdog_cnt    <= '0;
                        dom_idx     <= '0;
                        dom_reset_b <= '0;
                        seq_done    <= 1'b0;
                    end else begin
                        wdog_cnt <= wdog_cnt + CNT_W'(1);
                    end
                end

                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_reset_seq.sv
// Bench for m6809_reset_seq: two configurations driven in lockstep, checked every cycle
// against a time-since-release model plus directed checks at the interesting edges.
module tb_m6809_reset_seq;

    logic       clk = 1'b0;
    logic       rb = 1'b0;
    logic       sw = 1'b0;
    logic       ten = 1'b0;
    logic       kick = 1'b0;

    logic [1:0] dom0;
    logic       done0;
    logic       to0;
    logic [7:0] rc0;
    logic [3:0] dom1;
    logic       done1;
    logic       to1;
    logic [7:0] rc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    m6809_reset_seq u_dut0 (
        .clk          (clk),
        .reset_b      (rb),
        .sw_reset_req (sw),
        .timeout_en   (ten),
        .wdog_kick    (kick),
        .dom_reset_b  (dom0),
        .seq_done     (done0),
        .timeout      (to0),
        .restart_cnt  (rc0)
    );

    m6809_reset_seq #(
        .NUM_DOMAINS    (4),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (1),
        .TIMEOUT_CYCLES (2),
        .CNT_W          (4)
    ) u_dut1 (
        .clk          (clk),
        .reset_b      (rb),
        .sw_reset_req (sw),
        .timeout_en   (ten),
        .wdog_kick    (kick),
        .dom_reset_b  (dom1),
        .seq_done     (done1),
        .timeout      (to1),
        .restart_cnt  (rc1)
    );

    // Model: t = edges since the sequence last started; outputs follow from thresholds on t.
    int p_n[2] = '{2, 4};
    int p_h[2] = '{2, 1};
    int p_s[2] = '{4, 1};
    int p_t[2] = '{250, 2};

    int m_started[2] = '{0, 0};
    int m_t[2]       = '{0, 0};
    int m_wd[2]      = '{0, 0};
    int m_to[2]      = '{0, 0};
    int m_rc[2]      = '{0, 0};

    function automatic int run_time(input int k);
        return p_h[k] + (p_n[k] - 1) * p_s[k];
    endfunction

    task automatic model_step(input int k);
        if (!rb) begin
            m_started[k] = 0; m_t[k] = 0; m_wd[k] = 0; m_to[k] = 0; m_rc[k] = 0;
        end else if (m_started[k] == 0) begin
            m_started[k] = 1; m_t[k] = 0; m_wd[k] = 0;
        end else if (sw) begin
            m_t[k] = 0; m_wd[k] = 0;
        end else if (m_t[k] >= run_time(k)) begin
            if (kick || !ten) begin
                m_wd[k] = 0;
            end else if (m_wd[k] == p_t[k] - 1) begin
                m_to[k] = 1;
                if (m_rc[k] < 255) m_rc[k] = m_rc[k] + 1;
                m_t[k] = 0;
                m_wd[k] = 0;
            end else begin
                m_wd[k] = m_wd[k] + 1;
            end
        end else begin
            m_t[k] = m_t[k] + 1;
        end
    endtask

    function automatic logic [7:0] exp_dom(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < p_n[k]; i++)
            if (m_started[k] != 0 && m_t[k] >= p_h[k] + i * p_s[k]) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] exp_done(input int k);
        return (m_started[k] != 0 && m_t[k] >= run_time(k)) ? 8'd1 : 8'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            check("m_dom0",  8'(dom0),  exp_dom(0));
            check("m_done0", 8'(done0), exp_done(0));
            check("m_to0",   8'(to0),   8'(m_to[0]));
            check("m_rc0",   rc0,       8'(m_rc[0]));
            check("m_dom1",  8'(dom1),  exp_dom(1));
            check("m_done1", 8'(done1), exp_done(1));
            check("m_to1",   8'(to1),   8'(m_to[1]));
            check("m_rc1",   rc1,       8'(m_rc[1]));
        end
    endtask

    initial begin
        // Power-up release with defaults; the second instance shows 1-cycle staging.
        tick(2);
        check("rst_dom0", 8'(dom0), 8'h00);
        check("rst_rc0", rc0, 8'h00);
        rb = 1'b1;
        tick(1);
        check("e0_dom0", 8'(dom0), 8'h00);
        check("e0_dom1", 8'(dom1), 8'h00);
        tick(1);
        check("e1_dom0", 8'(dom0), 8'h00);
        check("e1_dom1", 8'(dom1), 8'h01);
        tick(1);
        check("e2_dom0", 8'(dom0), 8'h01);
        check("e2_dom1", 8'(dom1), 8'h03);
        tick(1);
        check("e3_dom1", 8'(dom1), 8'h07);
        check("e3_done1", 8'(done1), 8'h00);
        tick(1);
        check("e4_dom1", 8'(dom1), 8'h0F);
        check("e4_done1", 8'(done1), 8'h01);
        tick(1);
        check("e5_dom0", 8'(dom0), 8'h01);
        check("e5_done0", 8'(done0), 8'h00);
        tick(1);
        check("e6_dom0", 8'(dom0), 8'h03);
        check("e6_done0", 8'(done0), 8'h01);
        check("e6_to0", 8'(to0), 8'h00);

        // Watchdog expiry 250 edges after RUN entry, then re-release.
        ten = 1'b1;
        tick(249);
        check("pre_exp_to0", 8'(to0), 8'h00);
        check("pre_exp_done0", 8'(done0), 8'h01);
        tick(1);
        check("exp_to0", 8'(to0), 8'h01);
        check("exp_rc0", rc0, 8'h01);
        check("exp_dom0", 8'(dom0), 8'h00);
        check("exp_done0", 8'(done0), 8'h00);
        tick(2);
        check("rerel_b0", 8'(dom0), 8'h01);
        tick(4);
        check("rerel_b1", 8'(dom0), 8'h03);
        check("rerel_done", 8'(done0), 8'h01);

        // Clear the sticky flag, then kick every 100 cycles for 1000 cycles.
        rb = 1'b0;
        tick(1);
        check("rst2_to0", 8'(to0), 8'h00);
        check("rst2_rc0", rc0, 8'h00);
        rb = 1'b1;
        tick(7);
        check("run2_done0", 8'(done0), 8'h01);
        for (int i = 0; i < 1000; i++) begin
            kick = (i % 100 == 99);
            tick(1);
            check("kick_to0", 8'(to0), 8'h00);
            check("kick_done0", 8'(done0), 8'h01);
        end

        // Kick exactly on the expiry edge.
        kick = 1'b1;
        tick(1);
        kick = 1'b0;
        tick(249);
        kick = 1'b1;
        tick(1);
        check("kick_edge_to0", 8'(to0), 8'h00);
        check("kick_edge_done0", 8'(done0), 8'h01);
        kick = 1'b0;

        // Software restart exactly on the expiry edge.
        tick(249);
        sw = 1'b1;
        tick(1);
        check("sw_edge_to0", 8'(to0), 8'h00);
        check("sw_edge_rc0", rc0, 8'h00);
        check("sw_edge_dom0", 8'(dom0), 8'h00);
        check("sw_edge_done0", 8'(done0), 8'h00);
        // Held request keeps every domain in reset.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("sw_hold_dom0", 8'(dom0), 8'h00);
            check("sw_hold_dom1", 8'(dom1), 8'h00);
        end
        sw = 1'b0;
        tick(2);
        check("sw_rel_b0", 8'(dom0), 8'h01);
        tick(4);
        check("sw_rel_b1", 8'(dom0), 8'h03);

        // reset_b during STAGGER after bit 0 has been released.
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        tick(3);
        check("stag_dom0", 8'(dom0), 8'h01);
        rb = 1'b0;
        tick(1);
        check("stag_rst_dom0", 8'(dom0), 8'h00);
        check("stag_rst_dom1", 8'(dom1), 8'h00);
        check("stag_rst_done1", 8'(done1), 8'h00);
        check("stag_rst_rc1", rc1, 8'h00);
        rb = 1'b1;
        tick(1);
        tick(2);
        check("stag_re_b0", 8'(dom0), 8'h01);
        tick(4);
        check("stag_re_b1", 8'(dom0), 8'h03);

        // Random traffic checked against the model.
        for (int i = 0; i < 2000; i++) begin
            rb   = ($urandom_range(63) != 0);
            sw   = ($urandom_range(31) == 0);
            ten  = ($urandom_range(7) != 0);
            kick = ($urandom_range(63) == 0);
            tick(1);
        end

        // Free-running expiries drive the short-timeout instance into saturation.
        rb = 1'b1; sw = 1'b0; ten = 1'b1; kick = 1'b0;
        tick(1600);
        check("sat_rc1", rc1, 8'hFF);
        check("sat_to1", 8'(to1), 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
